// File: rtl/mul_add_pipe_pkg.sv
// Shared types for the mul_add_pipe multiply-add pipeline.
// Payload words are sized for the widest supported WIDTH; upper bits stay zero.
package mul_add_pipe_pkg;

    localparam int unsigned PIPE_DEPTH = 3;
    localparam int unsigned MAX_WIDTH  = 64;

    typedef logic [MAX_WIDTH-1:0] word_t;

    typedef struct packed {
        word_t x;
        word_t y;
        word_t z;
        logic  acc;
    } s0_t;

    typedef struct packed {
        word_t p;
        word_t z;
        logic  acc;
    } s1_t;

endpackage

// File: rtl/mul_add_pipe_slice.sv
// Generic valid/ready register slice: one beat of storage, full throughput.
module mul_add_pipe_slice
    import mul_add_pipe_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    assign ready_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_i && ready_o) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mul_add_pipe.sv
// Three-stage back-pressured multiply-add: out = (x*y + (acc ? acc_q : z)) mod 2^WIDTH.
// S0 holds operands, S1 holds the truncated product, S2 holds the sum.
module mul_add_pipe
    import mul_add_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] acc_value,
    output logic             busy
);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("mul_add_pipe: WIDTH out of range");
    end

    s0_t s0_in, s0_q;
    s1_t s1_in, s1_q;

    logic [PIPE_DEPTH-1:0] stage_valid;
    logic                  ready1, ready2;

    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] acc_q, acc_d;

    always_comb begin
        s0_in     = '0;
        s0_in.x   = word_t'(in_x);
        s0_in.y   = word_t'(in_y);
        s0_in.z   = word_t'(in_z);
        s0_in.acc = in_acc;
    end

    mul_add_pipe_slice #(
        .W($bits(s0_t))
    ) u_s0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (in_valid),
        .ready_o (in_ready),
        .data_i  (s0_in),
        .valid_o (stage_valid[0]),
        .ready_i (ready1),
        .data_o  (s0_q)
    );

    // Operands are zero-extended, so the low WIDTH bits of the wide product are exact.
    assign prod = WIDTH'(s0_q.x * s0_q.y);

    always_comb begin
        s1_in     = '0;
        s1_in.p   = word_t'(prod);
        s1_in.z   = s0_q.z;
        s1_in.acc = s0_q.acc;
    end

    mul_add_pipe_slice #(
        .W($bits(s1_t))
    ) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (stage_valid[0]),
        .ready_o (ready1),
        .data_i  (s1_in),
        .valid_o (stage_valid[1]),
        .ready_i (ready2),
        .data_o  (s1_q)
    );

    assign addend = s1_q.acc ? acc_q : WIDTH'(s1_q.z);
    assign sum    = WIDTH'(s1_q.p) + addend;

    mul_add_pipe_slice #(
        .W(WIDTH)
    ) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (stage_valid[1]),
        .ready_o (ready2),
        .data_i  (sum),
        .valid_o (stage_valid[2]),
        .ready_i (out_ready),
        .data_o  (s2_q)
    );

    // Accumulator follows every beat entering S2, so chained acc beats need no bubble.
    assign acc_d = (stage_valid[1] && ready2) ? sum : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign out_valid = stage_valid[2];
    assign out_data  = s2_q;
    assign acc_value = acc_q;
    assign busy      = |stage_valid;

endmodule
